// File: rtl/ofs_plat_prim_fairness_pkg.sv
// Shared helpers for the N-channel burst-count fairness tracker.
// Holds the window-sum width rule, the default threshold multiplier and the max-reduction select.
package ofs_plat_prim_fairness_pkg;

    localparam int FAIRNESS_DEFAULT_THRESHOLD_SHIFT = 3;
    localparam int FAIRNESS_CMP_W = 64;

    function automatic int fairness_sum_width(input int burst_w, input int depth);
        return burst_w + 1 + $clog2(depth + 1);
    endfunction

    // Returns 1 only when b is strictly larger, so equal sums keep the lower channel index.
    function automatic logic max_idx(input logic [FAIRNESS_CMP_W-1:0] a,
                                     input logic [FAIRNESS_CMP_W-1:0] b);
        return (b > a);
    endfunction

endpackage

// File: rtl/ofs_plat_prim_fairness_chan_window.sv
// One channel's sliding window: beat history, running sum and activity vector.
// The window advances on active cycles only; idle cycles neither age nor add.
module ofs_plat_prim_fairness_chan_window
    import ofs_plat_prim_fairness_pkg::*;
#(
    parameter int BEAT_W        = 8,
    parameter int HISTORY_DEPTH = 31,
    parameter int SUM_W         = fairness_sum_width(BEAT_W - 1, HISTORY_DEPTH)
)(
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     clear,
    input  logic                     i_ch_valid,
    input  logic                     i_any_valid,
    input  logic [BEAT_W-1:0]        i_beats,
    input  logic                     i_beats_en,
    output logic [SUM_W-1:0]         o_sum,
    output logic [HISTORY_DEPTH-1:0] o_active
);

    logic [BEAT_W-1:0]        r_hist [HISTORY_DEPTH];
    logic [SUM_W-1:0]         r_sum;
    logic [HISTORY_DEPTH-1:0] r_active;

    // NOTE: the history is reset with the sum; the running sum subtracts whatever leaves the
    // window, so stale entries after reset or clear would corrupt it.
    always_ff @(posedge clk) begin
        if (!reset_n || clear) begin
            r_sum <= '0;
            for (int i = 0; i < HISTORY_DEPTH; i++) begin
                r_hist[i] <= '0;
            end
        end else if (i_beats_en) begin
            r_sum     <= r_sum + SUM_W'(i_beats) - SUM_W'(r_hist[HISTORY_DEPTH-1]);
            r_hist[0] <= i_beats;
            for (int i = 1; i < HISTORY_DEPTH; i++) begin
                r_hist[i] <= r_hist[i-1];
            end
        end
    end

    // Activity follows the raw request, one cycle ahead of the beat history.
    always_ff @(posedge clk) begin
        if (!reset_n || clear) begin
            r_active <= '0;
        end else if (i_any_valid) begin
            r_active <= {r_active[HISTORY_DEPTH-2:0], i_ch_valid};
        end
    end

    assign o_sum    = r_sum;
    assign o_active = r_active;

endmodule

// File: rtl/ofs_plat_prim_burstcount_fairness_multi.sv
// N-channel burst-count fairness tracker: flags active channels lagging the busiest one.
// Define OFS_PLAT_PRIM_FAIRNESS_MAX_PIPE_EN to register the max reduction (latency 4 instead of 3).
module ofs_plat_prim_burstcount_fairness_multi
    import ofs_plat_prim_fairness_pkg::*;
#(
    parameter int NUM_CH              = 4,
    parameter int BURST_CNT_WIDTH     = 7,
    parameter int HISTORY_DEPTH       = 31,
    parameter int FAIRNESS_THRESHOLD  = FAIRNESS_DEFAULT_THRESHOLD_SHIFT << BURST_CNT_WIDTH,
    parameter int BURST_CNT_IS_MINUS1 = 0
)(
    input  logic                                   clk,
    input  logic                                   reset_n,
    input  logic                                   clear,
    input  logic [NUM_CH-1:0]                      ch_valid,
    input  logic [NUM_CH-1:0][BURST_CNT_WIDTH-1:0] ch_burstcount,
    output logic [NUM_CH-1:0]                      favor,
    output logic [$clog2(NUM_CH)-1:0]              busiest_ch
);

    localparam int BEAT_W    = BURST_CNT_WIDTH + 1;
    localparam int SUM_W     = fairness_sum_width(BURST_CNT_WIDTH, HISTORY_DEPTH);
    localparam int IDX_W     = $clog2(NUM_CH);
    localparam int NUM_PAIRS = (NUM_CH + 1) / 2;

    typedef logic [BEAT_W-1:0] beat_t;
    typedef logic [SUM_W-1:0]  sum_t;
    typedef logic [IDX_W-1:0]  idx_t;

    localparam sum_t THRESHOLD = SUM_W'(FAIRNESS_THRESHOLD);

    beat_t             w_beats [NUM_CH];
    logic              w_any_valid;
    beat_t             r_beats [NUM_CH];
    logic              r_any_valid;
    sum_t              w_sum [NUM_CH];
    logic [NUM_CH-1:0] w_active;

    // NOTE: every output of a combinational block is assigned on every path, so no latch forms.
    always_comb begin
        w_any_valid = |ch_valid;
        for (int i = 0; i < NUM_CH; i++) begin
            w_beats[i] = ch_valid[i] ? (beat_t'(ch_burstcount[i]) + beat_t'(BURST_CNT_IS_MINUS1))
                                     : '0;
        end
    end

    // NOTE: state registers use non-blocking assignment so all stages sample pre-edge values.
    always_ff @(posedge clk) begin
        if (!reset_n || clear) begin
            r_any_valid <= 1'b0;
            for (int i = 0; i < NUM_CH; i++) begin
                r_beats[i] <= '0;
            end
        end else begin
            r_any_valid <= w_any_valid;
            for (int i = 0; i < NUM_CH; i++) begin
                r_beats[i] <= w_beats[i];
            end
        end
    end

    for (genvar g = 0; g < NUM_CH; g++) begin : g_chan
        logic [HISTORY_DEPTH-1:0] w_active_vec;

        ofs_plat_prim_fairness_chan_window #(
            .BEAT_W        (BEAT_W),
            .HISTORY_DEPTH (HISTORY_DEPTH),
            .SUM_W         (SUM_W)
        ) u_window (
            .clk         (clk),
            .reset_n     (reset_n),
            .clear       (clear),
            .i_ch_valid  (ch_valid[g]),
            .i_any_valid (w_any_valid),
            .i_beats     (r_beats[g]),
            .i_beats_en  (r_any_valid),
            .o_sum       (w_sum[g]),
            .o_active    (w_active_vec)
        );

        assign w_active[g] = |w_active_vec;
    end

    sum_t w_pair_sum [NUM_PAIRS];
    idx_t w_pair_idx [NUM_PAIRS];
    sum_t w_max_sum;
    idx_t w_max_idx;

    // First level compares neighbours; an odd last channel passes straight through.
    for (genvar p = 0; p < NUM_PAIRS; p++) begin : g_pair
        if (2 * p + 1 < NUM_CH) begin : g_two
            logic w_pick_hi;
            assign w_pick_hi     = max_idx(FAIRNESS_CMP_W'(w_sum[2*p]), FAIRNESS_CMP_W'(w_sum[2*p+1]));
            assign w_pair_sum[p] = w_pick_hi ? w_sum[2*p+1] : w_sum[2*p];
            assign w_pair_idx[p] = w_pick_hi ? idx_t'(2 * p + 1) : idx_t'(2 * p);
        end else begin : g_one
            assign w_pair_sum[p] = w_sum[2*p];
            assign w_pair_idx[p] = idx_t'(2 * p);
        end
    end

    always_comb begin
        w_max_sum = w_pair_sum[0];
        w_max_idx = w_pair_idx[0];
        for (int p = 1; p < NUM_PAIRS; p++) begin
            if (max_idx(FAIRNESS_CMP_W'(w_max_sum), FAIRNESS_CMP_W'(w_pair_sum[p]))) begin
                w_max_sum = w_pair_sum[p];
                w_max_idx = w_pair_idx[p];
            end
        end
    end

    sum_t              w_cmp_max;
    idx_t              w_cmp_idx;
    sum_t              w_cmp_sum [NUM_CH];
    logic [NUM_CH-1:0] w_cmp_active;

`ifdef OFS_PLAT_PRIM_FAIRNESS_MAX_PIPE_EN
    sum_t              r_max_sum;
    idx_t              r_max_idx;
    sum_t              r_sum_d [NUM_CH];
    logic [NUM_CH-1:0] r_active_d;

    // Sums and activity are delayed with the max so the favor compare stays self-consistent.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_max_sum  <= '0;
            r_max_idx  <= '0;
            r_active_d <= '0;
            for (int i = 0; i < NUM_CH; i++) begin
                r_sum_d[i] <= '0;
            end
        end else begin
            r_max_sum  <= w_max_sum;
            r_max_idx  <= w_max_idx;
            r_active_d <= w_active;
            for (int i = 0; i < NUM_CH; i++) begin
                r_sum_d[i] <= w_sum[i];
            end
        end
    end

    assign w_cmp_max    = r_max_sum;
    assign w_cmp_idx    = r_max_idx;
    assign w_cmp_sum    = r_sum_d;
    assign w_cmp_active = r_active_d;
`else
    assign w_cmp_max    = w_max_sum;
    assign w_cmp_idx    = w_max_idx;
    assign w_cmp_sum    = w_sum;
    assign w_cmp_active = w_active;
`endif

    // Clear needs no special case here: zeroed sums drive favor and busiest_ch back to 0.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            favor      <= '0;
            busiest_ch <= '0;
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                favor[i] <= w_cmp_active[i] && ((w_cmp_max - w_cmp_sum[i]) > THRESHOLD);
            end
            busiest_ch <= w_cmp_idx;
        end
    end

endmodule
